// File: rtl/gate_layer_reduce_pipe.sv
// Gate layer (AND/NOT/OR pattern with wrap-around) feeding a registered FANIN-ary
// reduction tree. Includes valid/ready handshaking and a saturating count of f=1 results.
module gate_layer_reduce_pipe #(
  parameter int N       = 30,
  parameter int FANIN   = 4,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       a,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               f,
  input  logic               cnt_clr,
  output logic [COUNT_W-1:0] ones_count
);

  function automatic int stage_width(input int k);
    int w;
    w = N;
    for (int s = 0; s < k; s++) w = (w + FANIN - 1) / FANIN;
    return w;
  endfunction

  function automatic int num_stages();
    int w;
    int s;
    w = N;
    s = 0;
    while (w > 1) begin
      w = (w + FANIN - 1) / FANIN;
      s++;
    end
    return s;
  endfunction

  localparam int S = num_stages();

  logic en;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k <= S; k++) begin : g_stage
    localparam int W = stage_width(k);

    logic [W-1:0] red_d, red_q;
    logic [1:0]   mode_d, mode_q;
    logic         valid_d, valid_q;

    if (k == 0) begin : g_gate
      logic [N-1:0] gate_out;

      always_comb begin
        gate_out = '0;
        for (int i = 0; i < N; i++) begin
          case (i % 3)
            0:       gate_out[i] = a[i] & a[(i + 1) % N];
            1:       gate_out[i] = ~a[i];
            default: gate_out[i] = a[i] | a[(i + 1) % N];
          endcase
        end
      end

      always_comb begin
        red_d   = red_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        if (en) begin
          red_d   = gate_out;
          mode_d  = mode;
          valid_d = in_valid;
        end
      end
    end else begin : g_red
      localparam int WP   = stage_width(k - 1);
      localparam bit LAST = (k == S);

      logic [W*FANIN-1:0] padded;
      logic [1:0]         pmode;
      logic               ident;
      logic               acc;

      // Short last group is padded with the identity of the active reduction.
      always_comb begin
        pmode            = g_stage[k-1].mode_q;
        ident            = (pmode == 2'b01);
        padded           = {(W*FANIN){ident}};
        padded[WP-1:0]   = g_stage[k-1].red_q;
        acc              = 1'b0;
        red_d            = red_q;
        mode_d           = mode_q;
        valid_d          = valid_q;
        if (en) begin
          mode_d  = pmode;
          valid_d = g_stage[k-1].valid_q;
          for (int g = 0; g < W; g++) begin
            acc = padded[g*FANIN];
            for (int m = 1; m < FANIN; m++) begin
              case (pmode)
                2'b01:   acc = acc & padded[g*FANIN+m];
                2'b10:   acc = acc ^ padded[g*FANIN+m];
                default: acc = acc | padded[g*FANIN+m];
              endcase
            end
            red_d[g] = (LAST && pmode == 2'b11) ? ~acc : acc;
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        red_q   <= '0;
        mode_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        red_q   <= red_d;
        mode_q  <= mode_d;
        valid_q <= valid_d;
      end
    end
  end

  assign out_valid = g_stage[S].valid_q;
  assign f         = g_stage[S].red_q[0];

  logic [COUNT_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (cnt_clr) begin
      count_d = '0;
    end else if (out_valid && out_ready && f && count_q != {COUNT_W{1'b1}}) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign ones_count = count_q;

endmodule

// File: tb/tb_gate_layer_reduce_pipe.sv
// Directed bench for gate_layer_reduce_pipe: the default build, a COUNT_W=2 copy
// sharing its stimulus, and a small N=7/FANIN=2 build driven separately.
module tb_gate_layer_reduce_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, inValid, outReady, cntClr;
   logic [29:0] a;
   logic [1:0]  mode;
   logic        inReady, outValid, f;
   logic [15:0] onesCount;

   logic        inReadySat, outValidSat, fSat;
   logic [1:0]  onesCountSat;

   logic        inValid7, inReady7, outValid7, f7;
   logic [6:0]  a7;
   logic [1:0]  mode7;
   logic [15:0] onesCount7;

   int checks = 0;
   int errors = 0;
   int cycleCount = 0;
   logic expectedQ[$];

   gate_layer_reduce_pipe #(.N(30), .FANIN(4), .COUNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
      .a(a), .mode(mode), .out_valid(outValid), .out_ready(outReady),
      .f(f), .cnt_clr(cntClr), .ones_count(onesCount)
   );

   gate_layer_reduce_pipe #(.N(30), .FANIN(4), .COUNT_W(2)) dutSat (
      .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReadySat),
      .a(a), .mode(mode), .out_valid(outValidSat), .out_ready(outReady),
      .f(fSat), .cnt_clr(cntClr), .ones_count(onesCountSat)
   );

   gate_layer_reduce_pipe #(.N(7), .FANIN(2), .COUNT_W(16)) dutSmall (
      .clk(clk), .rst_n(rst_n), .in_valid(inValid7), .in_ready(inReady7),
      .a(a7), .mode(mode7), .out_valid(outValid7), .out_ready(1'b1),
      .f(f7), .cnt_clr(1'b0), .ones_count(onesCount7)
   );

   // Free-running cycle counter used to measure streaming throughput.
   always @(posedge clk) cycleCount++;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Presents one transaction (called at posedge+1), waits for in_ready and queues the expected f.
   task automatic applyStimulus(input logic [29:0] av, input logic [1:0] mv, input logic expF);
      int guard = 0;
      inValid = 1'b1;
      a       = av;
      mode    = mv;
      while (!inReady && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      checkOutput("accept_wait", 32'(guard < 50), 32'd1);
      expectedQ.push_back(expF);
      @(posedge clk); #1;
   endtask

   // Waits until every queued result has been observed, then lets the counter settle.
   task automatic drainPipe();
      int guard = 0;
      while (expectedQ.size() != 0 && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      checkOutput("drain_done", 32'(expectedQ.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   // Output monitor: every transfer of the main DUT must match the next queued result in order.
   always @(negedge clk) begin
      if (rst_n && outValid && outReady) begin
         if (expectedQ.size() == 0) checkOutput("unexpected_out", 32'(outValid), 32'd0);
         else                       checkOutput("f_order", 32'(f), 32'(expectedQ.pop_front()));
      end
   end

   // Watchdog so the run always ends on its own.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [6:0] smallA [6];
      logic [1:0] smallMode [6];
      logic       smallF [6];
      int startCycle;
      int guard;

      smallA[0] = 7'b0010010; smallMode[0] = 2'b00; smallF[0] = 1'b0;
      smallA[1] = 7'b0010010; smallMode[1] = 2'b11; smallF[1] = 1'b1;
      smallA[2] = 7'b1000000; smallMode[2] = 2'b10; smallF[2] = 1'b1;
      smallA[3] = 7'b1000001; smallMode[3] = 2'b10; smallF[3] = 1'b0;
      smallA[4] = 7'b1111111; smallMode[4] = 2'b01; smallF[4] = 1'b0;
      smallA[5] = 7'b0000000; smallMode[5] = 2'b00; smallF[5] = 1'b1;

      rst_n = 1'b0; inValid = 1'b0; a = '0; mode = 2'b00; outReady = 1'b1; cntClr = 1'b0;
      inValid7 = 1'b0; a7 = '0; mode7 = 2'b00;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      checkOutput("reset_out_valid", 32'(outValid), 32'd0);
      checkOutput("reset_f", 32'(f), 32'd0);
      checkOutput("reset_count", 32'(onesCount), 32'd0);
      checkOutput("reset_in_ready", 32'(inReady), 32'd1);

      // All NOT inputs high, so every gate output is 0: OR gives 0, NOR gives 1, latency 4.
      applyStimulus(30'h12492492, 2'b00, 1'b0);
      inValid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checkOutput("latency_not_yet", 32'(outValid), 32'd0);
         @(posedge clk); #1;
      end
      checkOutput("latency_valid", 32'(outValid), 32'd1);
      applyStimulus(30'h12492492, 2'b11, 1'b1);
      inValid = 1'b0;
      drainPipe();
      checkOutput("count_after_nor", 32'(onesCount), 32'd1);

      // a=0: ten NOT outputs high -> OR 1, XOR 0, AND 0.
      applyStimulus(30'h0, 2'b00, 1'b1);
      applyStimulus(30'h0, 2'b10, 1'b0);
      applyStimulus(30'h0, 2'b01, 1'b0);
      inValid = 1'b0;
      drainPipe();
      checkOutput("count_after_a0", 32'(onesCount), 32'd2);

      applyStimulus(30'h3fffffff, 2'b01, 1'b0);
      inValid = 1'b0;
      drainPipe();
      cntClr = 1'b1;
      @(posedge clk); #1;
      cntClr = 1'b0;
      checkOutput("count_cleared", 32'(onesCount), 32'd0);

      // Twenty back-to-back transactions alternating OR/NOR with a=0.
      startCycle = cycleCount;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(30'h0, (i % 2 == 0) ? 2'b00 : 2'b11, (i % 2 == 0) ? 1'b1 : 1'b0);
      end
      checkOutput("stream_cycles", 32'(cycleCount - startCycle), 32'd20);
      inValid = 1'b0;
      drainPipe();
      checkOutput("stream_count", 32'(onesCount), 32'd10);

      // Reset with three transactions in flight drops them all.
      applyStimulus(30'h0, 2'b00, 1'b1);
      applyStimulus(30'h0, 2'b00, 1'b1);
      applyStimulus(30'h0, 2'b00, 1'b1);
      inValid = 1'b0;
      rst_n   = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      expectedQ.delete();
      checkOutput("midreset_out_valid", 32'(outValid), 32'd0);
      checkOutput("midreset_count", 32'(onesCount), 32'd0);
      checkOutput("midreset_in_ready", 32'(inReady), 32'd1);
      repeat (6) @(posedge clk);
      #1 checkOutput("midreset_no_stale", 32'(outValid), 32'd0);

      // Back-pressure: pipeline fills with four, then holds.
      outReady = 1'b0;
      applyStimulus(30'h0, 2'b00, 1'b1);
      applyStimulus(30'h0, 2'b11, 1'b0);
      applyStimulus(30'h0, 2'b10, 1'b0);
      applyStimulus(30'h0, 2'b00, 1'b1);
      inValid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         checkOutput("hold_out_valid", 32'(outValid), 32'd1);
         checkOutput("hold_in_ready", 32'(inReady), 32'd0);
         checkOutput("hold_f", 32'(f), 32'd1);
         @(posedge clk); #1;
      end
      outReady = 1'b1;
      drainPipe();
      checkOutput("hold_count", 32'(onesCount), 32'd2);

      // Saturation of the 2-bit counter, and clear beating a same-cycle increment.
      cntClr = 1'b1;
      @(posedge clk); #1;
      cntClr = 1'b0;
      for (int i = 0; i < 5; i++) applyStimulus(30'h0, 2'b00, 1'b1);
      inValid = 1'b0;
      drainPipe();
      checkOutput("sat_count", 32'(onesCountSat), 32'd3);
      checkOutput("wide_count", 32'(onesCount), 32'd5);
      applyStimulus(30'h0, 2'b00, 1'b1);
      inValid = 1'b0;
      guard   = 0;
      while (!outValid && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      checkOutput("clr_wait", 32'(outValid), 32'd1);
      cntClr = 1'b1;
      @(posedge clk); #1;
      cntClr = 1'b0;
      checkOutput("clr_priority_sat", 32'(onesCountSat), 32'd0);
      checkOutput("clr_priority_wide", 32'(onesCount), 32'd0);
      drainPipe();

      // N=7, FANIN=2 build: latency 4 and the wrap gate d[6] = a[6] & a[0].
      for (int v = 0; v < 6; v++) begin
         inValid7 = 1'b1;
         a7       = smallA[v];
         mode7    = smallMode[v];
         checkOutput("small_in_ready", 32'(inReady7), 32'd1);
         @(posedge clk); #1;
         inValid7 = 1'b0;
         for (int c = 0; c < 3; c++) begin
            checkOutput("small_latency_not_yet", 32'(outValid7), 32'd0);
            @(posedge clk); #1;
         end
         checkOutput("small_valid", 32'(outValid7), 32'd1);
         checkOutput("small_f", 32'(f7), 32'(smallF[v]));
         @(posedge clk); #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
